// File: rtl/cache_mem_responder.sv
// Backing-memory responder for the 2-way data cache: one word read/write at a
// time over valid/ready request/response channels after a fixed latency.
// Words never written read back as their own byte address.
module cache_mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WA_W  = ADDR_W - 2;

    // Reject illegal parameterisations at elaboration
    if (LATENCY == 0) begin : g_bad_latency
        $error("cache_mem_responder: LATENCY must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cache_mem_responder: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
        $error("cache_mem_responder: ADDR_W too narrow for DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              we_q;
    logic [WA_W-1:0]   waddr_q;
    logic [31:0]       wdata_q;
    logic              cap_en;

    logic [31:0]       mem [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic              mem_we;

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [31:0]       fill_data;

    // Byte-offset bits carry no meaning for word accesses
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];

    // Decode the captured word address
    always_comb begin
        idx       = waddr_q[IDX_W-1:0];
        in_range  = ((waddr_q >> IDX_W) == '0);
        fill_data = 32'({waddr_q, 2'b00});
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        busy_d       = busy_q;
        cap_en       = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cap_en      = 1'b1;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = S_WAIT;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    if (!in_range) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (we_q) begin
                        mem_we  = !rst;
                        rdata_d = 32'h0;
                    end else begin
                        rdata_d = written_q[idx] ? mem[idx] : fill_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    err_d        = 1'b0;
                    rdata_d      = 32'h0;
                    busy_d       = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Captured request; inputs are free to change after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0;
        end else if (cap_en) begin
            we_q    <= req_we;
            waddr_q <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
        end
    end

    // Written-word tracking, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else if (mem_we) begin
            written_q[idx] <= 1'b1;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule
